// File: rtl/ad9280_scop_axis_packer_pkg.sv
// Shared types and constants for the AD9280 scope sample packer.
// Holds the FSM encoding, byte-lane geometry and the tkeep mask helper.
package ad9280_scop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int LANES      = 4;
  localparam int LANE_CNT_W = 2;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = LANES * BYTE_W;

  localparam logic [LANE_CNT_W-1:0] LAST_LANE = 2'd3;

  // Number of filled lanes (0..4) to an LSB-first tkeep mask.
  function automatic logic [LANES-1:0] lane_mask(input logic [LANE_CNT_W:0] n);
    logic [LANES-1:0] m;
    case (n)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ad9280_scop_axis_packer_if.sv
// AXI4-Stream output bundle of the packer; master drives data, slave drives ready.
interface ad9280_scop_axis_if;
  import ad9280_scop_pkg::*;

  logic [WORD_W-1:0] m_axis_tdata;
  logic [LANES-1:0]  m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tlast,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tlast,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/ad9280_scop_axis_packer.sv
// Packs decimated 8-bit ADC samples into 32-bit AXI-Stream words grouped into frames,
// with abort flushing of partial frames when enable drops.
module ad9280_scop_axis_packer
  import ad9280_scop_pkg::*;
#(
  parameter int FRAME_LEN_WIDTH = 16,
  parameter int DECIM_WIDTH     = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       s_valid,
  input  logic [BYTE_W-1:0]          s_data,
  output logic                       s_ready,
  input  logic                       enable,
  input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
  input  logic [DECIM_WIDTH-1:0]     decim,
  ad9280_scop_axis_if.master         m_axis,
  output logic                       frame_done,
  output logic [FRAME_LEN_WIDTH-1:0] frame_count,
  output logic                       frame_aborted
);

  localparam logic [FRAME_LEN_WIDTH-1:0] LEN_ZERO = {FRAME_LEN_WIDTH{1'b0}};
  localparam logic [FRAME_LEN_WIDTH-1:0] LEN_ONE  = {{(FRAME_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DECIM_WIDTH-1:0]     DEC_ZERO = {DECIM_WIDTH{1'b0}};
  localparam logic [DECIM_WIDTH-1:0]     DEC_ONE  = {{(DECIM_WIDTH-1){1'b0}}, 1'b1};

  state_t                     r_state;
  logic [FRAME_LEN_WIDTH-1:0] r_len;
  logic [DECIM_WIDTH-1:0]     r_decim;
  logic [DECIM_WIDTH-1:0]     r_dcnt;
  logic [FRAME_LEN_WIDTH-1:0] r_kept;
  logic [LANE_CNT_W-1:0]      r_lane_cnt;
  logic [3*BYTE_W-1:0]        r_lanes;
  logic [WORD_W-1:0]          r_tdata;
  logic [LANES-1:0]           r_tkeep;
  logic                       r_tlast;
  logic                       r_tvalid;
  logic                       r_frame_done;
  logic [FRAME_LEN_WIDTH-1:0] r_frame_count;
  logic                       r_aborted;

  state_t                     w_state_nxt;
  logic                       w_start;
  logic                       w_flush_load;
  logic                       w_out_free;
  logic                       w_out_hs;
  logic                       w_s_ready;
  logic                       w_acc;
  logic                       w_keep;
  logic                       w_last;
  logic                       w_emit;
  logic [FRAME_LEN_WIDTH-1:0] w_kept_inc;
  logic [WORD_W-1:0]          w_word;

  assign w_out_free = !r_tvalid || m_axis.m_axis_tready;
  assign w_out_hs   = r_tvalid && m_axis.m_axis_tready;
  assign w_s_ready  = (r_state == ST_RUN) && w_out_free;
  assign w_acc      = s_valid && w_s_ready;
  assign w_keep     = w_acc && (r_dcnt == DEC_ZERO);
  assign w_kept_inc = r_kept + LEN_ONE;
  assign w_last     = w_keep && (w_kept_inc == r_len);
  assign w_emit     = w_keep && ((r_lane_cnt == LAST_LANE) || w_last);

  // Next-state logic; a flush word is only loaded once the output register is free.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_flush_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_out_free && (r_kept != LEN_ZERO)) begin
          w_flush_load = 1'b1;
        end else if (w_out_free) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Merge the incoming byte into the pending lanes; lanes above it stay zero.
  always_comb begin
    w_word = {WORD_W{1'b0}};
    case (r_lane_cnt)
      2'd0:    w_word = {24'h000000, s_data};
      2'd1:    w_word = {16'h0000, s_data, r_lanes[7:0]};
      2'd2:    w_word = {8'h00, s_data, r_lanes[15:0]};
      default: w_word = {s_data, r_lanes};
    endcase
  end

  // State, output word, frame counters and status registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_len         <= LEN_ZERO;
      r_decim       <= DEC_ZERO;
      r_dcnt        <= DEC_ZERO;
      r_kept        <= LEN_ZERO;
      r_lane_cnt    <= {LANE_CNT_W{1'b0}};
      r_lanes       <= {(3*BYTE_W){1'b0}};
      r_tdata       <= {WORD_W{1'b0}};
      r_tkeep       <= {LANES{1'b0}};
      r_tlast       <= 1'b0;
      r_tvalid      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= LEN_ZERO;
      r_aborted     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_out_hs && r_tlast;
      if (w_out_hs && r_tlast) begin
        r_frame_count <= r_frame_count + LEN_ONE;
      end else begin
        r_frame_count <= r_frame_count;
      end

      if (w_emit) begin
        r_tdata  <= w_word;
        r_tkeep  <= lane_mask({1'b0, r_lane_cnt} + 3'd1);
        r_tlast  <= w_last;
        r_tvalid <= 1'b1;
      end else if (w_flush_load) begin
        r_tdata  <= {8'h00, r_lanes};
        r_tkeep  <= lane_mask({1'b0, r_lane_cnt});
        r_tlast  <= 1'b1;
        r_tvalid <= 1'b1;
      end else if (w_out_hs) begin
        r_tvalid <= 1'b0;
      end else begin
        r_tvalid <= r_tvalid;
      end

      if (w_start) begin
        r_len      <= (frame_len == LEN_ZERO) ? LEN_ONE : frame_len;
        r_decim    <= decim;
        r_dcnt     <= DEC_ZERO;
        r_kept     <= LEN_ZERO;
        r_lane_cnt <= {LANE_CNT_W{1'b0}};
        r_lanes    <= {(3*BYTE_W){1'b0}};
        r_aborted  <= 1'b0;
      end else if (w_flush_load) begin
        r_kept     <= LEN_ZERO;
        r_lane_cnt <= {LANE_CNT_W{1'b0}};
        r_lanes    <= {(3*BYTE_W){1'b0}};
        r_aborted  <= 1'b1;
      end else if (w_acc && w_last) begin
        // Frame complete: next accepted sample opens a fresh frame.
        r_dcnt     <= DEC_ZERO;
        r_kept     <= LEN_ZERO;
        r_lane_cnt <= {LANE_CNT_W{1'b0}};
        r_lanes    <= {(3*BYTE_W){1'b0}};
      end else if (w_acc) begin
        r_dcnt <= (r_dcnt == r_decim) ? DEC_ZERO : (r_dcnt + DEC_ONE);
        if (w_keep && (r_lane_cnt == LAST_LANE)) begin
          r_kept     <= w_kept_inc;
          r_lane_cnt <= {LANE_CNT_W{1'b0}};
          r_lanes    <= {(3*BYTE_W){1'b0}};
        end else if (w_keep) begin
          r_kept     <= w_kept_inc;
          r_lane_cnt <= r_lane_cnt + 2'd1;
          r_lanes    <= w_word[3*BYTE_W-1:0];
        end else begin
          r_kept <= r_kept;
        end
      end else begin
        r_dcnt <= r_dcnt;
      end
    end
  end

  assign s_ready              = w_s_ready;
  assign m_axis.m_axis_tdata  = r_tdata;
  assign m_axis.m_axis_tkeep  = r_tkeep;
  assign m_axis.m_axis_tlast  = r_tlast;
  assign m_axis.m_axis_tvalid = r_tvalid;
  assign frame_done           = r_frame_done;
  assign frame_count          = r_frame_count;
  assign frame_aborted        = r_aborted;

endmodule

// File: tb/tb_ad9280_scop_axis_packer.sv
// Directed self-checking bench for ad9280_scop_axis_packer: framing, decimation,
// back-pressure, abort flush, zero-length frames and mid-frame reset.
module tb_ad9280_scop_axis_packer;
  import ad9280_scop_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        enable;
  logic [15:0] frame_len;
  logic [7:0]  decim;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        frame_aborted;

  ad9280_scop_axis_if axis ();

  ad9280_scop_axis_packer #(.FRAME_LEN_WIDTH(16), .DECIM_WIDTH(8)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .enable        (enable),
    .frame_len     (frame_len),
    .decim         (decim),
    .m_axis        (axis),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .frame_aborted (frame_aborted)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks;
  int failures;
  int idx;
  int nbytes;
  int done_cnt;
  int stall_left;
  int stall_cyc;
  int stall_err;
  int exp_fc;
  logic [7:0] bytes [0:31];
  word_t got_q [$];
  word_t stall_snap;

  // One clock cycle: drive at the falling edge, observe shortly after.
  task automatic step(input logic want_valid);
    @(negedge sys_clk);
    s_valid = want_valid && (idx < nbytes);
    s_data  = s_valid ? bytes[idx] : 8'h00;
    if (stall_left > 0 && axis.m_axis_tvalid) begin
      if (stall_cyc == 0)
        stall_snap = '{axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast};
      axis.m_axis_tready = 1'b0;
      stall_left--;
      stall_cyc++;
    end else begin
      axis.m_axis_tready = 1'b1;
    end
    #1;
    if (!axis.m_axis_tready) begin
      if (s_ready || (word_t'{axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast} != stall_snap))
        stall_err++;
    end
    if (frame_done) done_cnt++;
    if (axis.m_axis_tvalid && axis.m_axis_tready)
      got_q.push_back('{axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast});
    if (s_valid && s_ready) idx++;
  endtask

  task automatic run(input int exp_words, input string name);
    int cyc = 0;
    idx = 0; done_cnt = 0; stall_cyc = 0; stall_err = 0;
    got_q.delete();
    while ((idx < nbytes || got_q.size() < exp_words) && cyc < 300) begin
      step(1'b1);
      cyc++;
    end
    checks++;
    if (cyc >= 300) begin
      failures++;
      $display("FAIL %s_timeout: sent=%0d words=%0d, required sent=%0d words=%0d",
               name, idx, got_q.size(), nbytes, exp_words);
    end
    repeat (3) step(1'b0);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    repeat (3) step(1'b0);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tkeep, s_ready, frame_done, frame_aborted} !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got=%b required=0", {axis.m_axis_tvalid, axis.m_axis_tlast,
               axis.m_axis_tkeep, s_ready, frame_done, frame_aborted});
    end
    checks++;
    if (axis.m_axis_tdata !== 32'h0 || frame_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: tdata=%h count=%0d required 0/0", axis.m_axis_tdata, frame_count);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    word_t exp_w [2];
    word_t obs;
    exp_w[0] = '{32'h04030201, 4'hF, 1'b0};
    exp_w[1] = '{32'h08070605, 4'hF, 1'b1};
    for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
    nbytes = 8; frame_len = 16'd8; decim = 8'd0; enable = 1'b1;
    run(2, "full");
    exp_fc = exp_fc + 1;
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL full_nwords: got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (obs !== exp_w[i]) begin
        failures++;
        $display("FAIL full_word%0d: got=%h required=%h", i, obs, exp_w[i]);
      end
    end
    checks++;
    if (frame_count !== 16'(exp_fc) || done_cnt != 1) begin
      failures++;
      $display("FAIL full_count: count=%0d done=%0d required %0d/1", frame_count, done_cnt, exp_fc);
    end
    stop_run();
  endtask

  task automatic test_partial_word();
    word_t exp_w [2];
    word_t obs;
    exp_w[0] = '{32'h13121110, 4'hF, 1'b0};
    exp_w[1] = '{32'h00001514, 4'b0011, 1'b1};
    for (int i = 0; i < 6; i++) bytes[i] = 8'(8'h10 + i);
    nbytes = 6; frame_len = 16'd6; decim = 8'd0; enable = 1'b1;
    run(2, "partial");
    exp_fc = exp_fc + 1;
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL partial_nwords: got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (obs !== exp_w[i]) begin
        failures++;
        $display("FAIL partial_word%0d: got=%h required=%h", i, obs, exp_w[i]);
      end
    end
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL partial_count: got=%0d required=%0d", frame_count, exp_fc);
    end
    stop_run();
  endtask

  task automatic test_decimation();
    word_t exp_w;
    word_t obs;
    exp_w = '{32'h09060300, 4'hF, 1'b1};
    for (int i = 0; i < 10; i++) bytes[i] = 8'(i);
    nbytes = 10; frame_len = 16'd4; decim = 8'd2; enable = 1'b1;
    run(1, "decim");
    exp_fc = exp_fc + 1;
    obs = (got_q.size() > 0) ? got_q[0] : '0;
    checks++;
    if (got_q.size() != 1 || obs !== exp_w) begin
      failures++;
      $display("FAIL decim_word: n=%0d got=%h required 1 word %h", got_q.size(), obs, exp_w);
    end
    checks++;
    if (frame_count !== 16'(exp_fc) || done_cnt != 1) begin
      failures++;
      $display("FAIL decim_count: count=%0d done=%0d required %0d/1", frame_count, done_cnt, exp_fc);
    end
    stop_run();
  endtask

  task automatic test_backpressure();
    word_t exp_w [2];
    word_t obs;
    exp_w[0] = '{32'h04030201, 4'hF, 1'b0};
    exp_w[1] = '{32'h08070605, 4'hF, 1'b1};
    for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
    nbytes = 8; frame_len = 16'd8; decim = 8'd0; enable = 1'b1;
    stall_left = 5;
    run(2, "stall");
    stall_left = 0;
    exp_fc = exp_fc + 1;
    checks++;
    if (stall_cyc != 5 || stall_err != 0) begin
      failures++;
      $display("FAIL stall_hold: stalled=%0d violations=%0d required 5/0", stall_cyc, stall_err);
    end
    for (int i = 0; i < 2; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (obs !== exp_w[i]) begin
        failures++;
        $display("FAIL stall_word%0d: got=%h required=%h", i, obs, exp_w[i]);
      end
    end
    checks++;
    if (got_q.size() != 2 || frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL stall_count: words=%0d count=%0d required 2/%0d", got_q.size(), frame_count, exp_fc);
    end
    stop_run();
  endtask

  task automatic test_abort();
    word_t exp_w [2];
    word_t obs;
    exp_w[0] = '{32'h04030201, 4'hF, 1'b0};
    exp_w[1] = '{32'h00000005, 4'b0001, 1'b1};
    for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
    nbytes = 5; frame_len = 16'd16; decim = 8'd0; enable = 1'b1;
    run(1, "abort");
    checks++;
    if (frame_aborted !== 1'b0) begin
      failures++;
      $display("FAIL abort_early: aborted=%b required=0", frame_aborted);
    end
    enable = 1'b0;
    repeat (4) step(1'b0);
    exp_fc = exp_fc + 1;
    for (int i = 0; i < 2; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (obs !== exp_w[i]) begin
        failures++;
        $display("FAIL abort_word%0d: got=%h required=%h", i, obs, exp_w[i]);
      end
    end
    checks++;
    if (frame_aborted !== 1'b1 || dut.r_state !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_state: aborted=%b state=%0d required 1/IDLE", frame_aborted, dut.r_state);
    end
    checks++;
    if (frame_count !== 16'(exp_fc) || done_cnt != 1 || got_q.size() != 2) begin
      failures++;
      $display("FAIL abort_count: count=%0d done=%0d words=%0d required %0d/1/2",
               frame_count, done_cnt, got_q.size(), exp_fc);
    end
    nbytes = 0;
    enable = 1'b1;
    step(1'b0);
    step(1'b0);
    checks++;
    if (frame_aborted !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: aborted=%b required=0", frame_aborted);
    end
    stop_run();
  endtask

  task automatic test_len_zero();
    word_t exp_w [2];
    word_t obs;
    exp_w[0] = '{32'h000000AA, 4'b0001, 1'b1};
    exp_w[1] = '{32'h000000BB, 4'b0001, 1'b1};
    bytes[0] = 8'hAA; bytes[1] = 8'hBB;
    nbytes = 2; frame_len = 16'd0; decim = 8'd0; enable = 1'b1;
    run(2, "len0");
    exp_fc = exp_fc + 2;
    for (int i = 0; i < 2; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (obs !== exp_w[i]) begin
        failures++;
        $display("FAIL len0_word%0d: got=%h required=%h", i, obs, exp_w[i]);
      end
    end
    checks++;
    if (frame_count !== 16'(exp_fc) || done_cnt != 2) begin
      failures++;
      $display("FAIL len0_count: count=%0d done=%0d required %0d/2", frame_count, done_cnt, exp_fc);
    end
    stop_run();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 8; i++) bytes[i] = 8'(8'h40 + i);
    nbytes = 8; frame_len = 16'd8; decim = 8'd0; enable = 1'b1;
    idx = 0; stall_cyc = 0; stall_left = 100;
    repeat (7) step(1'b1);
    checks++;
    if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 32'h43424140) begin
      failures++;
      $display("FAIL rstmid_pre: tvalid=%b tdata=%h required 1/43424140",
               axis.m_axis_tvalid, axis.m_axis_tdata);
    end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    #1;
    checks++;
    if ({axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tkeep, s_ready, frame_done, frame_aborted} !== 9'd0) begin
      failures++;
      $display("FAIL rstmid_ctrl: got=%b required=0", {axis.m_axis_tvalid, axis.m_axis_tlast,
               axis.m_axis_tkeep, s_ready, frame_done, frame_aborted});
    end
    checks++;
    if (axis.m_axis_tdata !== 32'h0 || frame_count !== 16'h0) begin
      failures++;
      $display("FAIL rstmid_data: tdata=%h count=%0d required 0/0", axis.m_axis_tdata, frame_count);
    end
    stall_left = 0;
    enable = 1'b0;
    sys_rst_n = 1'b1;
    repeat (2) step(1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; exp_fc = 0;
    idx = 0; nbytes = 0; done_cnt = 0;
    stall_left = 0; stall_cyc = 0; stall_err = 0;
    stall_snap = '0;
    sys_rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    enable = 1'b0; frame_len = 16'd0; decim = 8'd0;
    axis.m_axis_tready = 1'b1;
    test_reset();
    test_full_frame();
    test_partial_word();
    test_decimation();
    test_backpressure();
    test_abort();
    test_len_zero();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad9280_scop_axis_packer.md
AD9280_SCOP_AXIS_PACKER -- requirements
Module: ad9280_scop_axis_packer

Interface
REQ-001 Parameter FRAME_LEN_WIDTH, default 16, width of frame length and frame counter.
REQ-002 Parameter DECIM_WIDTH, default 8, width of decimation factor.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-005 s_valid  in  1  8-bit sample available from ADC core FIFO.
REQ-006 s_data  in  8  sample byte.
REQ-007 s_ready  out  1  sample accepted when s_valid && s_ready.
REQ-008 enable  in  1  packing enable; falling edge mid-frame aborts frame.
REQ-009 frame_len  in  FRAME_LEN_WIDTH  kept samples per frame.
REQ-010 decim  in  DECIM_WIDTH  keep one of every decim+1 accepted samples.
REQ-011 m_axis_tdata  out  32  packed samples.
REQ-012 m_axis_tkeep  out  4  valid byte lanes.
REQ-013 m_axis_tlast  out  1  last word of frame.
REQ-014 m_axis_tvalid  out  1  output word valid.
REQ-015 m_axis_tready  in  1  downstream ready.
REQ-016 frame_done  out  1  one-cycle pulse on tlast handshake.
REQ-017 frame_count  out  FRAME_LEN_WIDTH  frames emitted, wraps to 0.
REQ-018 frame_aborted  out  1  sticky, set on abort flush, cleared when enable rises.

Function
REQ-019 States IDLE, RUN, FLUSH; IDLE->RUN when enable=1; RUN->FLUSH when enable=0; FLUSH->IDLE once flush word is handshaken.
REQ-020 On IDLE->RUN, frame_len and decim are latched; changes take effect only at next frame start.
REQ-021 Latched frame_len of 0 is treated as 1.
REQ-022 s_ready = (state==RUN) && (!m_axis_tvalid || m_axis_tready); s_ready=0 in IDLE and FLUSH.
REQ-023 Decimation counter runs 0..decim on accepted samples, reset at frame start; sample kept when counter==0; decim=0 keeps every sample.
REQ-024 Discarded samples are consumed but not packed or counted.
REQ-025 Kept samples fill lanes in order: first kept sample in tdata[7:0], fourth in tdata[31:24].
REQ-026 Word issued on same edge the 4th lane or the frame's final kept sample is accepted; m_axis_tvalid high the following cycle (1-cycle latency).
REQ-027 Final word of frame: tlast=1, tkeep marks filled lanes LSB-first (e.g. 2 bytes -> 4'b0011), unused lanes zero.
REQ-028 After frame end, decimation and byte counters restart; next frame begins with next accepted sample, no idle cycle.
REQ-029 While m_axis_tvalid=1 and m_axis_tready=0, tdata/tkeep/tlast are held stable.
REQ-030 Full throughput: one sample per cycle sustained with m_axis_tready=1.
REQ-031 Abort: in FLUSH, if frame kept count > 0, emit one word with partial lanes (tkeep may be 4'b0000), tlast=1, set frame_aborted; if kept count == 0, no word emitted, go IDLE.
REQ-032 FLUSH waits for any pending output word to handshake before issuing flush word.
REQ-033 frame_count increments and frame_done pulses on every tlast handshake, including aborts.

Reset
REQ-034 sys_rst_n=0 at an edge: state=IDLE, all counters, lanes, s_ready, m_axis_tvalid, tdata, tkeep, tlast, frame_done, frame_count, frame_aborted = 0.
REQ-035 Reset mid-frame discards pending word without handshake; no frame_done.

Structure
REQ-036 State encoding localparams and lane-count constants reside in shared package ad9280_scop_pkg.
REQ-037 Single module; no sub-modules required.

Verification
REQ-038 frame_len=8, decim=0, bytes 0x01..0x08, tready=1 -> words 0x04030201 (tkeep F, tlast 0), 0x08070605 (tkeep F, tlast 1); frame_count=1.
REQ-039 frame_len=6, decim=0, bytes 0x10..0x15 -> 0x13121110, then 0x00001514 tkeep 4'b0011 tlast 1.
REQ-040 frame_len=4, decim=2, bytes 0x00..0x0B -> single word 0x09060300, tlast 1.
REQ-041 frame_len=8, tready low 5 cycles at first word -> s_ready=0, word stable, no byte loss, same output as REQ-038.
REQ-042 frame_len=16, enable drops after 5 kept bytes -> word 0x..., then 0x00000005-lane word tkeep 4'b0001 tlast 1, frame_aborted=1, state IDLE.
REQ-043 sys_rst_n low mid-frame with tvalid=1 -> next cycle tvalid=0, frame_count=0, all outputs 0.
